// File: rtl/fwd_ctrl_if.sv
// rtl/fwd_ctrl_if.sv - ID-stage hazard inputs and forwarding/stall outputs of fwd_ctrl
// master = decode stage driving ID fields, slave = fwd_ctrl.
interface fwd_ctrl_if #(parameter int REG_AW = 3);
  logic              id_valid;
  logic [REG_AW-1:0] id_rs1;
  logic [REG_AW-1:0] id_rs2;
  logic              id_imm_b;
  logic [REG_AW-1:0] id_rd;
  logic              id_we;
  logic              id_load;
  logic              flush;
  logic [1:0]        sel_a;
  logic [1:0]        sel_b;
  logic              stall;

  modport master (
    output id_valid, id_rs1, id_rs2, id_imm_b, id_rd, id_we, id_load, flush,
    input  sel_a, sel_b, stall
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_imm_b, id_rd, id_we, id_load, flush,
    output sel_a, sel_b, stall
  );
endinterface

// File: rtl/fwd_ctrl.sv
// rtl/fwd_ctrl.sv - EX/MEM/WB hazard tracker producing operand forwarding selects and load-use stall
// Optional FWD_STALL_CNT_EN adds a saturating 16-bit stall_cnt output.
module fwd_ctrl #(
  parameter int REG_AW   = 3,
  parameter int ZERO_REG = 1
) (
  input  logic      clk,
  input  logic      rst_n,
  fwd_ctrl_if.slave bus
`ifdef FWD_STALL_CNT_EN
  ,
  output logic [15:0] stall_cnt
`endif
);

  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic              we;
    logic              load;
  } slot_t;

  slot_t      ex_q, mem_q, wb_q, ex_d;
  logic [1:0] sel_a_q, sel_a_d, sel_b_q, sel_b_d;
  logic       stall_c;
  logic       advance;
  logic       unused_wb;

  function automatic logic hit(input logic [REG_AW-1:0] src, input slot_t s);
    return s.we && (src == s.rd) && !((ZERO_REG != 0) && (src == '0));
  endfunction

  // The EX slot is the younger producer, so it takes precedence over MEM.
  function automatic logic [1:0] fwd_sel(input logic [REG_AW-1:0] src,
                                         input slot_t ex, input slot_t mem);
    if (hit(src, ex))       return 2'b01;
    else if (hit(src, mem)) return 2'b10;
    else                    return 2'b00;
  endfunction

  always_comb begin
    stall_c = 1'b0;
    advance = 1'b0;
    ex_d    = '0;
    sel_a_d = 2'b00;
    sel_b_d = 2'b00;
    if (bus.id_valid && !bus.flush && ex_q.load) begin
      stall_c = hit(bus.id_rs1, ex_q) || (!bus.id_imm_b && hit(bus.id_rs2, ex_q));
    end
    advance = bus.id_valid && !bus.flush && !stall_c;
    if (advance) begin
      ex_d.rd   = bus.id_rd;
      ex_d.we   = bus.id_we;
      ex_d.load = bus.id_load;
      sel_a_d   = fwd_sel(bus.id_rs1, ex_q, mem_q);
      sel_b_d   = bus.id_imm_b ? 2'b11 : fwd_sel(bus.id_rs2, ex_q, mem_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q    <= '0;
      mem_q   <= '0;
      wb_q    <= '0;
      sel_a_q <= 2'b00;
      sel_b_q <= 2'b00;
    end else begin
      ex_q    <= ex_d;
      mem_q   <= ex_q;
      wb_q    <= mem_q;
      sel_a_q <= sel_a_d;
      sel_b_q <= sel_b_d;
    end
  end

  // WB retires into the register file, so nothing ever forwards from it.
  assign unused_wb = ^wb_q;

  assign bus.stall = stall_c;
  assign bus.sel_a = sel_a_q;
  assign bus.sel_b = sel_b_q;

`ifdef FWD_STALL_CNT_EN
  logic [15:0] stall_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= 16'd0;
    end else if (stall_c && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fwd_ctrl.sv
// tb/tb_fwd_ctrl.sv - directed table plus randomized reference-model check of fwd_ctrl
// Optional FWD_STALL_CNT_EN also checks stall_cnt.
module tb_fwd_ctrl;

  logic clk;
  logic rst_n;

  fwd_ctrl_if #(.REG_AW(3)) bus ();

`ifdef FWD_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  fwd_ctrl #(.REG_AW(3), .ZERO_REG(1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
`ifdef FWD_STALL_CNT_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       v;
    logic [2:0] rs1;
    logic [2:0] rs2;
    logic       imm;
    logic [2:0] rd;
    logic       we;
    logic       ld;
    logic       fl;
    logic       es;
    logic [1:0] ea;
    logic [1:0] eb;
  } vec_t;

  typedef struct packed {
    logic [2:0] rd;
    logic       we;
    logic       ld;
  } rec_t;

  int   n_vec = 0;
  int   n_bad = 0;
  vec_t tbl[20];
  rec_t hist[$];
  int   model_cnt;

  function automatic vec_t mk(input logic v, input int rs1, input int rs2, input logic imm,
                              input int rd, input logic we, input logic ld, input logic fl,
                              input logic es, input int ea, input int eb);
    vec_t r;
    r.v = v; r.rs1 = 3'(rs1); r.rs2 = 3'(rs2); r.imm = imm; r.rd = 3'(rd);
    r.we = we; r.ld = ld; r.fl = fl; r.es = es; r.ea = 2'(ea); r.eb = 2'(eb);
    return r;
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t t);
    bus.id_valid = t.v;   bus.id_rs1 = t.rs1; bus.id_rs2  = t.rs2;
    bus.id_imm_b = t.imm; bus.id_rd  = t.rd;  bus.id_we   = t.we;
    bus.id_load  = t.ld;  bus.flush  = t.fl;
  endtask

  // Drive mid-cycle, check combinational stall, then the selects registered at the edge.
  task automatic step(input vec_t t, input string name);
    @(negedge clk);
    drive(t);
    #1;
    chk({name, " stall"}, 16'(bus.stall), 16'(t.es));
    @(posedge clk);
    #1;
    chk({name, " sel_a"}, 16'(bus.sel_a), 16'(t.ea));
    chk({name, " sel_b"}, 16'(bus.sel_b), 16'(t.eb));
  endtask

  function automatic logic m_hit(input logic [2:0] src, input rec_t r);
    return r.we && (r.rd == src) && (src != 3'd0);
  endfunction

  function automatic logic [1:0] m_sel(input logic [2:0] src);
    for (int a = 0; a < 2; a++)
      if (m_hit(src, hist[a])) return (a == 0) ? 2'b01 : 2'b10;
    return 2'b00;
  endfunction

  initial begin
    clk = 1'b0;
    rst_n = 1'b0;
    drive(mk(1, 2, 2, 0, 0, 0, 0, 0, 0, 0, 0));
    #2;
    chk("reset stall", 16'(bus.stall), 16'd0);
    chk("reset sel_a", 16'(bus.sel_a), 16'd0);
    chk("reset sel_b", 16'(bus.sel_b), 16'd0);
`ifdef FWD_STALL_CNT_EN
    chk("reset stall_cnt", stall_cnt, 16'd0);
`endif
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post-reset stall", 16'(bus.stall), 16'd0);
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    //           v rs1 rs2 imm rd we ld fl  es ea eb
    tbl[0]  = mk(1, 0, 0, 0, 3, 1, 0, 0, 0, 0, 0);
    tbl[1]  = mk(1, 3, 1, 0, 0, 0, 0, 0, 0, 1, 0);
    tbl[2]  = mk(1, 1, 1, 0, 5, 1, 0, 0, 0, 0, 0);
    tbl[3]  = mk(1, 6, 7, 0, 4, 1, 0, 0, 0, 0, 0);
    tbl[4]  = mk(1, 0, 5, 0, 0, 0, 0, 0, 0, 0, 2);
    tbl[5]  = mk(1, 0, 0, 0, 2, 1, 1, 0, 0, 0, 0);
    tbl[6]  = mk(1, 2, 2, 0, 0, 0, 0, 0, 1, 0, 0);
    tbl[7]  = mk(1, 2, 2, 0, 0, 0, 0, 0, 0, 2, 2);
    tbl[8]  = mk(1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    tbl[9]  = mk(1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 3);
    tbl[10] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[11] = mk(1, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0);
    tbl[12] = mk(1, 0, 0, 0, 6, 1, 0, 0, 0, 0, 0);
    tbl[13] = mk(1, 1, 6, 0, 0, 0, 0, 0, 0, 2, 1);
    tbl[14] = mk(1, 0, 0, 0, 4, 1, 1, 0, 0, 0, 0);
    tbl[15] = mk(1, 0, 4, 1, 0, 0, 0, 0, 0, 0, 3);
    tbl[16] = mk(1, 0, 0, 0, 2, 1, 1, 0, 0, 0, 0);
    tbl[17] = mk(1, 2, 0, 1, 0, 0, 0, 1, 0, 0, 0);
    tbl[18] = mk(1, 2, 2, 0, 0, 0, 0, 0, 0, 2, 2);
    tbl[19] = mk(1, 0, 0, 0, 7, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 20; i++) step(tbl[i], $sformatf("row%0d", i));
`ifdef FWD_STALL_CNT_EN
    chk("table stall_cnt", stall_cnt, 16'd1);
`endif

    // Reset while a load sits in EX with a dependent instruction in ID.
    step(mk(1, 7, 0, 0, 2, 1, 1, 0, 0, 1, 0), "load into EX");
    @(negedge clk);
    drive(mk(1, 2, 0, 1, 0, 0, 0, 0, 0, 0, 0));
    #1;
    chk("pre-reset stall", 16'(bus.stall), 16'd1);
    rst_n = 1'b0;
    #1;
    chk("mid-reset stall", 16'(bus.stall), 16'd0);
    chk("mid-reset sel_a", 16'(bus.sel_a), 16'd0);
    chk("mid-reset sel_b", 16'(bus.sel_b), 16'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("release stall", 16'(bus.stall), 16'd0);
    @(posedge clk);
    #1;
    chk("release sel_a", 16'(bus.sel_a), 16'd0);
    chk("release sel_b", 16'(bus.sel_b), 16'd3);

    // Randomized run against the reference model, starting from a clean reset.
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    hist = '{};
    hist.push_back('0);
    hist.push_back('0);
    model_cnt = 0;
    for (int c = 0; c < 400; c++) begin
      vec_t r;
      logic adv;
      rec_t nw;
      r.v   = ($urandom_range(3) != 0);
      r.rs1 = 3'($urandom_range(3));
      r.rs2 = 3'($urandom_range(3));
      r.imm = ($urandom_range(3) == 0);
      r.rd  = 3'($urandom_range(3));
      r.we  = ($urandom_range(3) != 0);
      r.ld  = r.we && ($urandom_range(2) == 0);
      r.fl  = ($urandom_range(7) == 0);
      r.es  = r.v && !r.fl && hist[0].ld &&
              (m_hit(r.rs1, hist[0]) || (!r.imm && m_hit(r.rs2, hist[0])));
      adv   = r.v && !r.fl && !r.es;
      r.ea  = adv ? m_sel(r.rs1) : 2'b00;
      r.eb  = !adv ? 2'b00 : (r.imm ? 2'b11 : m_sel(r.rs2));
      step(r, $sformatf("rand%0d", c));
      nw.rd = r.rd; nw.we = r.we; nw.ld = r.ld;
      hist.push_front(adv ? nw : rec_t'('0));
      void'(hist.pop_back());
      if (r.es) model_cnt++;
    end
`ifdef FWD_STALL_CNT_EN
    chk("random stall_cnt", stall_cnt, 16'(model_cnt));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/fwd_ctrl.md
FWD_CTRL -- requirements
Module: fwd_ctrl

Interface
REQ-001 SHALL have parameter REG_AW, default 3: register-address width.
REQ-002 SHALL have parameter ZERO_REG, default 1: when 1, register address 0 is hard-wired and never forwarded or stalled on.
REQ-003 SHALL have port clk, input, 1: single clock; all state on rising edge.
REQ-004 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port id_valid, input, 1: the ID stage holds a real instruction.
REQ-006 SHALL have ports id_rs1 and id_rs2, input, REG_AW each: source register addresses.
REQ-007 SHALL have port id_imm_b, input, 1: operand B takes the immediate.
REQ-008 SHALL have port id_rd, input, REG_AW: destination register address.
REQ-009 SHALL have port id_we, input, 1: the instruction writes rd.
REQ-010 SHALL have port id_load, input, 1: the instruction is a load.
REQ-011 SHALL have port flush, input, 1: discard the ID instruction and bubble EX.
REQ-012 SHALL have port sel_a, output, 2: operand-A mux4 select. 00 = register file, 01 = EX/MEM result, 10 = MEM/WB result.
REQ-013 SHALL have port sel_b, output, 2: operand-B mux4 select. Codes as sel_a, plus 11 = immediate.
REQ-014 SHALL have port stall, output, 1: hold PC and IF/ID this cycle.

Function
REQ-015 SHALL track three slots, EX, MEM and WB, each holding {rd, we, load}; a slot with we=0 is a bubble.
REQ-016 SHALL shift the slots every cycle: WB<=MEM and MEM<=EX.
REQ-017 SHALL set EX<=ID fields when id_valid=1, stall=0 and flush=0; otherwise EX SHALL become a bubble.
REQ-018 SHALL define a hazard match as: (src==slot.rd) and slot.we=1 and not (ZERO_REG=1 and src==0).
REQ-019 SHALL assert stall combinationally (same cycle) when id_valid=1, flush=0 and an ID source matches the EX slot with EX.load=1. A source is rs1 always, and rs2 only when id_imm_b=0.
REQ-020 SHALL register sel_a/sel_b on the edge where ID advances into EX, so they are valid for the whole EX cycle (one-cycle latency from ID).
REQ-021 SHALL compute each select as: 01 if the source matches the EX slot (younger wins), else 10 if it matches the MEM slot, else 00.
REQ-022 SHALL force sel_b=11 when id_imm_b=1, overriding any forward.
REQ-023 SHALL load sel_a=sel_b=00 on any cycle EX receives a bubble (stall, flush or id_valid=0).
REQ-024 SHALL give flush priority over stall: with flush=1, stall SHALL be 0 and EX SHALL bubble.
REQ-025 SHALL evaluate rs1 and rs2 independently; both may forward from different slots in the same cycle.
REQ-026 SHALL stall exactly one cycle per load-use hazard. After the bubble, the load sits in MEM, and the dependent instruction SHALL advance with select 10.

Reset
REQ-027 SHALL, while rst_n=0, asynchronously clear all slots to bubbles (rd=0, we=0, load=0), sel_a=sel_b=00 and stall=0.
REQ-028 SHALL leave stall=0 on the first cycle after reset deassertion regardless of ID inputs, because all slots are bubbles.
REQ-029 SHALL treat a reset asserted mid-stall as discarding all in-flight hazard state.

Configuration
REQ-030 SHALL, when macro FWD_STALL_CNT_EN is defined, add output stall_cnt (16 bits). It counts cycles with stall=1, saturates at 0xFFFF, and clears on reset.
REQ-031 SHALL, when FWD_STALL_CNT_EN is undefined, have neither the stall_cnt port nor the counter logic, with all other behaviour identical.

Verification
REQ-032 SHALL cover back-to-back ALU dependence: I1 {rd=3, we=1}, then I2 {rs1=3} -> sel_a=01 during I2's EX cycle, stall never asserted.
REQ-033 SHALL cover distance-2 dependence: I1 writes r5, an unrelated I2, then I3 {rs2=5, imm_b=0} -> sel_b=10 during I3's EX cycle.
REQ-034 SHALL cover load-use: I1 {load, rd=2}, then I2 {rs1=2, rs2=2} -> stall=1 for exactly 1 cycle, with EX a bubble and sels 00 that cycle; then sel_a=sel_b=10 during I2's EX cycle. With FWD_STALL_CNT_EN, stall_cnt=1.
REQ-035 SHALL cover the zero register and immediate: I1 writes r0, then I2 {rs1=0, imm_b=1, rs2=0} -> sel_a=00 and sel_b=11, stall=0.
REQ-036 SHALL cover flush during a hazard: a load-use pair with flush=1 in the stall cycle -> stall=0, EX bubble, and the next-cycle sels 00.
REQ-037 SHALL cover reset mid-operation: rst_n low while EX holds a load -> sels 00 and stall 0 immediately, and no stall after release for rs1 matching the old rd.
